aes_sbox_sched: RTL and testbench

- Time-shares one combinational AES S-box (existing `sbox`, 8-bit `data`→`dout`) between two requesters.
  - State datapath: SubBytes, 16 bytes.
  - Key schedule: SubWord, 4 bytes.
- Arbitration is round-robin at job granularity.
- Each granted job is serialised one byte per cycle through the S-box; the substituted word is returned with a done pulse.
- Sits between the AES round controller/key expander and the single shared S-box instance.

---
 rtl/aes_pkg.sv | 19 +
 rtl/sbox.sv | 28 ++
 rtl/aes_sbox_sched.sv | 156 +++++++++++++++
 tb/tb_aes_sbox_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES scheduling types: FSM states, job owner and per-requester byte counts.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  typedef enum logic {
    OWN_ST = 1'b0,
    OWN_KS = 1'b1
  } owner_t;

  localparam logic [4:0] ST_BYTES = 5'd16;
  localparam logic [4:0] KS_BYTES = 5'd4;

endpackage

// File: rtl/sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module sbox (
  input  logic [7:0] data,
  output logic [7:0] dout
);

  localparam logic [7:0] TBL [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout = TBL[data];

endmodule

// File: rtl/aes_sbox_sched.sv
// Round-robin scheduler sharing one AES S-box between SubBytes (16 B) and SubWord (4 B) jobs.
// Handshake: req is a level held until the one-cycle gnt; done pulses with result valid.
module aes_sbox_sched
  import aes_pkg::*;
#(
  parameter int SBOX_PIPE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_req,
  input  logic [127:0] st_data,
  output logic         st_gnt,
  output logic         st_done,
  output logic [127:0] st_result,
  input  logic         ks_req,
  input  logic [31:0]  ks_data,
  output logic         ks_gnt,
  output logic         ks_done,
  output logic [31:0]  ks_result,
  output logic [7:0]   sb_in,
  input  logic [7:0]   sb_out,
  output logic         busy
);

  sched_state_t state;
  owner_t       owner;
  owner_t       last_owner;
  owner_t       grant_own;
  logic         grant_any;

  logic [127:0] working;
  logic [127:0] acc;
  logic [127:0] acc_nxt;
  logic [4:0]   iss_cnt;
  logic [4:0]   n_bytes;

  // sb_vld/sb_idx tag the byte currently on sb_in; p_* is the same tag one cycle later.
  logic         sb_vld;
  logic [3:0]   sb_idx;
  logic         p_vld;
  logic [3:0]   p_idx;
  logic         cap_vld;
  logic [3:0]   cap_idx;
  logic         last_issue_on_bus;

  assign busy = (state != IDLE);

  assign grant_any = st_req | ks_req;
  assign grant_own = (st_req && ks_req) ? ((last_owner == OWN_ST) ? OWN_KS : OWN_ST)
                   : (ks_req ? OWN_KS : OWN_ST);

  assign cap_vld = (SBOX_PIPE != 0) ? p_vld : sb_vld;
  assign cap_idx = (SBOX_PIPE != 0) ? p_idx : sb_idx;
  assign last_issue_on_bus = sb_vld && ({1'b0, sb_idx} == (n_bytes - 5'd1));

  always_comb begin
    acc_nxt = acc;
    if (cap_vld) acc_nxt[{cap_idx, 3'b000} +: 8] = sb_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_ST;
      last_owner <= OWN_ST;
      working    <= '0;
      acc        <= '0;
      iss_cnt    <= '0;
      n_bytes    <= '0;
      sb_vld     <= 1'b0;
      sb_idx     <= '0;
      p_vld      <= 1'b0;
      p_idx      <= '0;
      sb_in      <= '0;
      st_gnt     <= 1'b0;
      ks_gnt     <= 1'b0;
      st_done    <= 1'b0;
      ks_done    <= 1'b0;
      st_result  <= '0;
      ks_result  <= '0;
    end else begin
      st_gnt  <= 1'b0;
      ks_gnt  <= 1'b0;
      st_done <= 1'b0;
      ks_done <= 1'b0;
      p_vld   <= sb_vld;
      p_idx   <= sb_idx;
      acc     <= acc_nxt;
      case (state)
        // The DONE cycle itself never shows a gnt; its arbitration lands on the next cycle.
        IDLE, DONE: begin
          sb_in  <= '0;
          sb_vld <= 1'b0;
          if (grant_any) begin
            owner      <= grant_own;
            last_owner <= grant_own;
            iss_cnt    <= '0;
            acc        <= '0;
            state      <= RUN;
            if (grant_own == OWN_KS) begin
              ks_gnt  <= 1'b1;
              working <= {96'b0, ks_data};
              n_bytes <= KS_BYTES;
            end else begin
              st_gnt  <= 1'b1;
              working <= st_data;
              n_bytes <= ST_BYTES;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (iss_cnt < n_bytes) begin
            sb_in   <= working[7:0];
            working <= working >> 8;
            sb_vld  <= 1'b1;
            sb_idx  <= iss_cnt[3:0];
            iss_cnt <= iss_cnt + 5'd1;
          end else begin
            sb_in  <= '0;
            sb_vld <= 1'b0;
          end
          if (last_issue_on_bus) begin
            if (SBOX_PIPE == 0) begin
              state <= DONE;
              if (owner == OWN_ST) begin
                st_result <= acc_nxt;
                st_done   <= 1'b1;
              end else begin
                ks_result <= acc_nxt[31:0];
                ks_done   <= 1'b1;
              end
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          sb_in  <= '0;
          sb_vld <= 1'b0;
          state  <= DONE;
          if (owner == OWN_ST) begin
            st_result <= acc_nxt;
            st_done   <= 1'b1;
          end else begin
            ks_result <= acc_nxt[31:0];
            ks_done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Bench for aes_sbox_sched: one combinational-S-box instance and one registered-S-box instance.
module tb_aes_sbox_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;

  logic         st_req0, ks_req0, st_gnt0, ks_gnt0, st_done0, ks_done0, busy0;
  logic [127:0] st_data0, st_result0;
  logic [31:0]  ks_data0, ks_result0;
  logic [7:0]   sb_in0, sb_out0;

  logic         st_req1, ks_req1, st_gnt1, ks_gnt1, st_done1, ks_done1, busy1;
  logic [127:0] st_data1, st_result1;
  logic [31:0]  ks_data1, ks_result1;
  logic [7:0]   sb_in1, sb_comb1, sb_out1;

  logic [127:0] exp_st_q0[$], exp_ks_q0[$], exp_st_q1[$], exp_ks_q1[$];
  int           exp_st_c0[$], exp_ks_c0[$], exp_st_c1[$], exp_ks_c1[$];

  // clock/reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sbox u_sb0 (.data(sb_in0), .dout(sb_out0));
  sbox u_sb1 (.data(sb_in1), .dout(sb_comb1));
  always @(posedge clk) sb_out1 <= sb_comb1;

  aes_sbox_sched #(.SBOX_PIPE(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .st_req(st_req0), .st_data(st_data0), .st_gnt(st_gnt0), .st_done(st_done0), .st_result(st_result0),
    .ks_req(ks_req0), .ks_data(ks_data0), .ks_gnt(ks_gnt0), .ks_done(ks_done0), .ks_result(ks_result0),
    .sb_in(sb_in0), .sb_out(sb_out0), .busy(busy0)
  );

  aes_sbox_sched #(.SBOX_PIPE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .st_req(st_req1), .st_data(st_data1), .st_gnt(st_gnt1), .st_done(st_done1), .st_result(st_result1),
    .ks_req(ks_req1), .ks_data(ks_data1), .ks_gnt(ks_gnt1), .ks_done(ks_done1), .ks_result(ks_result1),
    .sb_in(sb_in1), .sb_out(sb_out1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference S-box from GF(2^8) inverse plus affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] model_word(input logic [127:0] d, input int n);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = sbox_model(d[8*k +: 8]);
    return r;
  endfunction

  // scoreboard: expectations pushed at each grant, popped on each done
  always @(negedge clk) begin
    if (st_gnt0 | ks_gnt0 | st_done0 | ks_done0)
      check("one_event0", 128'($countones({st_gnt0, ks_gnt0, st_done0, ks_done0})), 128'd1);
    if (st_gnt0) begin exp_st_q0.push_back(model_word(st_data0, 16)); exp_st_c0.push_back(cyc + 17); end
    if (ks_gnt0) begin exp_ks_q0.push_back(model_word({96'b0, ks_data0}, 4)); exp_ks_c0.push_back(cyc + 5); end
    if (st_done0) begin
      check("st_done_expected0", exp_st_q0.size() != 0, 1'b1);
      if (exp_st_q0.size() != 0) begin
        check("st_res0", st_result0, exp_st_q0.pop_front());
        check("st_lat0", cyc, exp_st_c0.pop_front());
      end
    end
    if (ks_done0) begin
      check("ks_done_expected0", exp_ks_q0.size() != 0, 1'b1);
      if (exp_ks_q0.size() != 0) begin
        check("ks_res0", ks_result0, exp_ks_q0.pop_front());
        check("ks_lat0", cyc, exp_ks_c0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (st_gnt1) begin exp_st_q1.push_back(model_word(st_data1, 16)); exp_st_c1.push_back(cyc + 18); end
    if (ks_gnt1) begin exp_ks_q1.push_back(model_word({96'b0, ks_data1}, 4)); exp_ks_c1.push_back(cyc + 6); end
    if (st_done1) begin
      check("st_done_expected1", exp_st_q1.size() != 0, 1'b1);
      if (exp_st_q1.size() != 0) begin
        check("st_res1", st_result1, exp_st_q1.pop_front());
        check("st_lat1", cyc, exp_st_c1.pop_front());
      end
    end
    if (ks_done1) begin
      check("ks_done_expected1", exp_ks_q1.size() != 0, 1'b1);
      if (exp_ks_q1.size() != 0) begin
        check("ks_res1", ks_result1, exp_ks_q1.pop_front());
        check("ks_lat1", cyc, exp_ks_c1.pop_front());
      end
    end
  end

  // driver tasks
  task automatic wait_gnt(input int sel, output int at);
    bit ok;
    ok = 1'b0;
    at = cyc;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (sel == 0 ? (st_gnt0 | ks_gnt0) : (st_gnt1 | ks_gnt1)) begin
        ok = 1'b1;
        at = cyc;
      end
    end
    check("gnt_timeout", ok, 1'b1);
  endtask

  task automatic wait_idle(input int sel);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (!(sel == 0 ? busy0 : busy1)) ok = 1'b1;
    end
    check("idle_timeout", ok, 1'b1);
  endtask

  task automatic run_job(input int sel, input bit is_st, input logic [127:0] d);
    int g;
    if (sel == 0) begin
      if (is_st) begin st_data0 = d; st_req0 = 1'b1; end
      else begin ks_data0 = d[31:0]; ks_req0 = 1'b1; end
    end else begin
      if (is_st) begin st_data1 = d; st_req1 = 1'b1; end
      else begin ks_data1 = d[31:0]; ks_req1 = 1'b1; end
    end
    wait_gnt(sel, g);
    check("gnt_owner", sel == 0 ? st_gnt0 : st_gnt1, is_st);
    st_req0 = 1'b0; ks_req0 = 1'b0; st_req1 = 1'b0; ks_req1 = 1'b0;
    wait_idle(sel);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g, g2, g3, g4;
    rst_n = 1'b0;
    st_req0 = 1'b0; ks_req0 = 1'b0; st_data0 = '0; ks_data0 = '0;
    st_req1 = 1'b0; ks_req1 = 1'b0; st_data1 = '0; ks_data1 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy0, 1'b0);
    check("rst_sb_in", sb_in0, 8'h00);
    check("rst_st_result", st_result0, 128'h0);
    check("rst_ks_result", ks_result0, 32'h0);
    check("rst_pulses", {st_gnt0, ks_gnt0, st_done0, ks_done0}, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);

    // contention straight out of reset, then both held high
    st_data0 = rand128(); ks_data0 = $urandom; st_req0 = 1'b1; ks_req0 = 1'b1;
    wait_gnt(0, g);
    check("cont_first_ks", ks_gnt0, 1'b1);
    check("cont_first_not_st", st_gnt0, 1'b0);
    ks_req0 = 1'b0;
    wait_gnt(0, g2);
    check("cont_st_gnt", st_gnt0, 1'b1);
    check("cont_st_at", g2, g + 6);
    st_req0 = 1'b0;
    repeat (4) @(negedge clk);
    ks_data0 = $urandom; st_req0 = 1'b1; ks_req0 = 1'b1;
    wait_gnt(0, g3);
    check("rr_ks", ks_gnt0, 1'b1);
    check("rr_ks_at", g3, g2 + 18);
    ks_req0 = 1'b0;
    wait_gnt(0, g4);
    check("rr_st", st_gnt0, 1'b1);
    check("rr_st_at", g4, g3 + 6);
    st_req0 = 1'b0;
    wait_idle(0);

    // KS only with known vector, busy window and done position
    ks_data0 = 32'h01FF5300; ks_req0 = 1'b1;
    wait_gnt(0, g);
    ks_req0 = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      check("t1_busy", busy0, i <= 5);
      check("t1_ks_done", ks_done0, i == 5);
      if (i == 5) check("t1_ks_result", ks_result0, 32'h7C16ED63);
      if (i < 6) @(negedge clk);
    end

    // ST only with known vector
    run_job(0, 1'b1, 128'h53);
    check("t2_st_result", st_result0, {{15{8'h63}}, 8'hED});
    check("t2_ks_untouched", ks_result0, 32'h7C16ED63);

    // req dropped and data changed mid-job
    ks_data0 = 32'hA5C3_1E07; ks_req0 = 1'b1;
    wait_gnt(0, g);
    @(negedge clk);
    @(negedge clk);
    ks_req0 = 1'b0; ks_data0 = 32'h0BAD_F00D;
    wait_idle(0);
    check("chg_ks_result", ks_result0, model_word({96'b0, 32'hA5C3_1E07}, 4));

    // randomised mix of jobs
    for (int j = 0; j < 6; j++) run_job(0, 1'($urandom_range(0, 1)), rand128());

    // registered S-box path
    run_job(1, 1'b0, 128'h0);
    check("p1_ks_result", ks_result1, 32'h63636363);
    run_job(1, 1'b1, rand128());
    run_job(1, 1'b0, rand128());

    // reset in the middle of an ST job
    st_data0 = rand128(); st_req0 = 1'b1;
    wait_gnt(0, g);
    st_req0 = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy0, 1'b0);
    check("abort_outputs", {st_gnt0, ks_gnt0, st_done0, ks_done0, sb_in0}, 12'h000);
    check("abort_st_result", st_result0, 128'h0);
    check("abort_ks_result", ks_result0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_st_q0.delete(); exp_st_c0.delete();
    repeat (25) @(negedge clk);
    check("abort_idle", busy0, 1'b0);
    check("abort_no_done_result", st_result0, 128'h0);
    st_data0 = rand128(); ks_data0 = $urandom; st_req0 = 1'b1; ks_req0 = 1'b1;
    wait_gnt(0, g);
    check("abort_next_ks", ks_gnt0, 1'b1);
    ks_req0 = 1'b0;
    wait_gnt(0, g2);
    st_req0 = 1'b0;
    wait_idle(0);

    check("q_st0_empty", exp_st_q0.size(), 0);
    check("q_ks0_empty", exp_ks_q0.size(), 0);
    check("q_st1_empty", exp_st_q1.size(), 0);
    check("q_ks1_empty", exp_ks_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
